// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: stream, configuration and status bundle for seq_detect_param
//   master (front end / control):
//     en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr
//     cfg_mask (only with SEQ_DET_MASK_EN defined)
//   slave (detector): pd, match_cnt, armed
interface seq_detect_param_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
);
    logic en;
    logic din_valid;
    logic din;
    logic cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic cfg_overlap;
    logic cnt_clr;
    logic pd;
    logic [CNT_W-1:0] match_cnt;
    logic armed;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
    modport master (
        output en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_mask, cnt_clr,
        input  pd, match_cnt, armed
    );
    modport slave (
        input  en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_mask, cnt_clr,
        output pd, match_cnt, armed
    );
`else
    modport master (
        output en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  pd, match_cnt, armed
    );
    modport slave (
        input  en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output pd, match_cnt, armed
    );
`endif
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector with saturating match counter
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seq_detect_param_if.slave
//        in : en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr
//        out: pd (one-cycle match pulse), match_cnt (saturating), armed (history holds >= len bits)
//   Optional: define SEQ_DET_MASK_EN to add cfg_mask (per-bit don't-care, 0 = ignore position).
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(8'b0001_0101)
) (
    input logic clk,
    input logic rst,
    seq_detect_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HUNT, ARMED} state_t;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
    state_t state, state_n;
    logic [PAT_W-1:0] hist, hist_n, pattern, mask, len_mask;
    logic [LEN_W-1:0] fill, fill_inc, fill_n, len, len_in;
    logic [CNT_W-1:0] cnt;
    logic overlap, accept, match, pd;
    always_comb begin
        accept = bus.din_valid & bus.en & ~bus.cfg_we;
        hist_n = {hist[PAT_W-2:0], bus.din};
        fill_inc = (fill == MAX_LEN) ? MAX_LEN : fill + 1'b1;
        for (int i = 0; i < PAT_W; i++) len_mask[i] = LEN_W'(i) < len;
        match = accept && (fill_inc >= len) && (((hist_n ^ pattern) & mask & len_mask) == '0);
        len_in = (bus.cfg_len == '0) ? LEN_W'(1) : (bus.cfg_len > MAX_LEN) ? MAX_LEN : bus.cfg_len;
        // non-overlapping mode restarts the fill so the next match needs len fresh bits
        fill_n = (bus.cfg_we || (match && !overlap)) ? '0 : accept ? fill_inc : fill;
        state_n = !bus.en ? IDLE : (fill_n < len) ? HUNT : ARMED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hist <= '0;
            fill <= '0;
            pattern <= PAT_RST;
            len <= MAX_LEN;
            overlap <= 1'b1;
            pd <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_n;
            fill <= fill_n;
            pd <= match;
            if (accept) hist <= hist_n;
            if (bus.cfg_we) begin
                pattern <= bus.cfg_pattern;
                len <= len_in;
                overlap <= bus.cfg_overlap;
            end
            cnt <= bus.cnt_clr ? CNT_W'(match) : (match && !(&cnt)) ? cnt + 1'b1 : cnt;
        end
    end
`ifdef SEQ_DET_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) mask <= '1;
        else if (bus.cfg_we) mask <= bus.cfg_mask;
    end
`else
    assign mask = '1;
`endif
    assign bus.pd = pd;
    assign bus.match_cnt = cnt;
    assign bus.armed = state == ARMED;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param (16-bit and 2-bit counter instances)
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] expa = 0;
    logic [15:0] expb = 0;
    always #5 clk = ~clk;
    seq_detect_param_if #(.PAT_W(8), .LEN_W(4), .CNT_W(16)) a();
    seq_detect_param_if #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) b();
    seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask
    // monitors: each pd pulse must match the oldest expected pulse and its counter value
    always @(negedge clk) begin
        if (a.pd === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pd_a_spurious: got pulse with match_cnt %0d expected no pulse", a.match_cnt);
            end else chk("pd_a_cnt", int'(a.match_cnt), int'(qa.pop_front()));
        end
        if (b.pd === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pd_b_spurious: got pulse with match_cnt %0d expected no pulse", b.match_cnt);
            end else chk("pd_b_cnt", int'(b.match_cnt), int'(qb.pop_front()));
        end
    end
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a.din_valid = 0; a.cfg_we = 0; a.cnt_clr = 0;
            b.din_valid = 0; b.cfg_we = 0; b.cnt_clr = 0;
        end
    endtask
    task automatic step(input logic d, input logic exp);
        @(negedge clk);
        a.din_valid = 1; a.din = d; a.cfg_we = 0; a.cnt_clr = 0;
        if (exp) begin
            expa = (expa == 16'hffff) ? expa : expa + 1;
            qa.push_back(expa);
        end
    endtask
    task automatic stepb(input logic d, input logic exp, input logic clr);
        @(negedge clk);
        b.din_valid = 1; b.din = d; b.cfg_we = 0; b.cnt_clr = clr;
        if (clr) expb = 0;
        if (exp) begin
            expb = (expb == 3) ? expb : expb + 1;
            qb.push_back(expb);
        end
    endtask
    task automatic cfga(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic d);
        @(negedge clk);
        a.cfg_we = 1; a.cfg_pattern = p; a.cfg_len = l; a.cfg_overlap = ov;
        a.din_valid = 1; a.din = d; a.cnt_clr = 0;
    endtask
    task automatic clra;
        @(negedge clk);
        a.din_valid = 0; a.cfg_we = 0; a.cnt_clr = 1;
        expa = 0;
    endtask
    task automatic chk_armed(input string n, input logic exp);
        @(posedge clk);
        #1;
        chk(n, int'(a.armed), int'(exp));
    endtask
    task automatic drain;
        idle(3);
        chk("qa_pending", qa.size(), 0);
        chk("qb_pending", qb.size(), 0);
    endtask
    initial begin
        logic [7:0] s1 = 8'b1010_0101;
        rst = 1;
        a.en = 1; a.din_valid = 0; a.din = 0; a.cfg_we = 0; a.cfg_pattern = 0; a.cfg_len = 0; a.cfg_overlap = 0; a.cnt_clr = 0;
        b.en = 1; b.din_valid = 0; b.din = 0; b.cfg_we = 0; b.cfg_pattern = 0; b.cfg_len = 0; b.cfg_overlap = 0; b.cnt_clr = 0;
`ifdef SEQ_DET_MASK_EN
        a.cfg_mask = '1;
        b.cfg_mask = '1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_pd", int'(a.pd), 0);
        chk("rst_cnt", int'(a.match_cnt), 0);
        chk("rst_armed", int'(a.armed), 0);
        chk("rst_armed_b", int'(b.armed), 0);
        rst = 0;
        // 2-bit counter: pattern 11 saturates, then clear coincident with a match gives 1
        @(negedge clk);
        b.cfg_we = 1; b.cfg_pattern = 8'b11; b.cfg_len = 2; b.cfg_overlap = 1; b.din_valid = 0;
        stepb(1, 0, 0);
        for (int k = 0; k < 5; k++) stepb(1, 1, 0);
        stepb(1, 1, 1);
        idle(2);
        chk("b_clr_match_cnt", int'(b.match_cnt), 1);
        drain;
        // overlapping 10101 on 1010101; bit offered during cfg must be dropped
        cfga(8'b10101, 5, 1, 1);
        chk_armed("cfg_drop_armed", 0);
        for (int k = 0; k < 7; k++) begin
            step(~k[0], k == 4 || k == 6);
            if (k == 3) chk_armed("t1_armed_b4", 0);
            if (k == 4) chk_armed("t1_armed_b5", 1);
        end
        drain;
        chk("t1_cnt", int'(a.match_cnt), 2);
        // non-overlapping on 11-bit alternating stream
        clra;
        cfga(8'b10101, 5, 0, 0);
        for (int k = 0; k < 11; k++) begin
            step(~k[0], k == 4 || k == 10);
            if (k == 4) chk_armed("t2_armed_after_match", 0);
        end
        drain;
        chk("t2_cnt", int'(a.match_cnt), 2);
        // gaps of three invalid cycles between bits
        clra;
        cfga(8'b10101, 5, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(~k[0], k == 4);
            if (k == 3) chk_armed("t3_armed_b4", 0);
            if (k == 4) chk_armed("t3_armed_b5", 1);
            idle(3);
        end
        drain;
        chk("t3_cnt", int'(a.match_cnt), 1);
        // reset mid-stream: restores PAT_RST/len 8, bits in flight lost
        cfga(8'b10101, 5, 1, 0);
        for (int k = 0; k < 4; k++) step(~k[0], 0);
        @(negedge clk);
        rst = 1; a.din_valid = 0;
        @(negedge clk);
        rst = 0;
        expa = 0;
        step(1, 0);
        chk_armed("t4_armed_after_rst", 0);
        chk("t4_cnt", int'(a.match_cnt), 0);
        for (int k = 0; k < 8; k++) step(s1[7-k] ^ (k < 7 ? 1'b0 : 1'b0) ? (8'b0001_0101 >> (7-k)) & 1 : (8'b0001_0101 >> (7-k)) & 1, k == 7);
        drain;
        chk("t4_cnt_rst_pat", int'(a.match_cnt), 1);
        // len 0 clamps to 1
        clra;
        cfga(8'b10101, 5, 1, 0);
        for (int k = 0; k < 4; k++) step(~k[0], 0);
        cfga(8'b10101, 0, 1, 1);
        chk_armed("t5_cfg_armed", 0);
        step(1, 1);
        chk_armed("t5_len1_armed", 1);
        step(0, 0);
        step(1, 1);
        drain;
        chk("t5_cnt", int'(a.match_cnt), 2);
        // len above PAT_W clamps to PAT_W
        cfga(s1, 15, 1, 0);
        for (int k = 0; k < 8; k++) begin
            step(s1[7-k], k == 7);
            if (k == 6) chk_armed("t6_armed_b7", 0);
        end
        drain;
        chk("t6_cnt", int'(a.match_cnt), 3);
        // en low forces IDLE; re-enable resumes ARMED from retained fill
        @(negedge clk);
        a.en = 0; a.din_valid = 1; a.din = 0;
        chk_armed("t7_idle", 0);
        @(negedge clk);
        a.en = 1; a.din_valid = 0;
        chk_armed("t7_resume", 1);
        drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
